// File: rtl/seq_multiplier_32bit_if.sv
// Start/operand/result bundle for the 32x32 sequential multiplier.
// Signal prefixes are from the multiplier's point of view.
interface seq_multiplier_32bit_if;
  logic        i_start;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic        o_busy;
  logic        o_done;
  logic [63:0] o_product;

  modport master (
    output i_start, i_a, i_b,
    input  o_busy, o_done, o_product
  );

  modport slave (
    input  i_start, i_a, i_b,
    output o_busy, o_done, o_product
  );
endinterface

// File: rtl/seq_multiplier_32bit.sv
// Shift-and-add 32x32 unsigned multiplier, one partial product per clock.
// Optional macro SEQ_MUL_EARLY_TERM_EN finishes as soon as the remaining multiplier bits are zero.
module full_adder_32bit (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_cin,
  output logic [31:0] o_sum,
  output logic        o_cout
);
  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {32'h0, i_cin};
endmodule

module seq_multiplier_32bit (
  input  logic                  clk,
  input  logic                  rst,
  seq_multiplier_32bit_if.slave bus
);
  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      r_state;
  logic [5:0]  r_count;
  logic [64:0] r_p;
  logic [31:0] r_mcand;
  logic        r_busy;
  logic        r_done;
  logic [63:0] r_product;

  logic [31:0] w_sum;
  logic        w_cout;
  logic [64:0] w_p_add;
  logic [64:0] w_p_shift;

  full_adder_32bit u_adder (
    .i_a    (r_p[63:32]),
    .i_b    (r_mcand),
    .i_cin  (1'b0),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // The adder carry lands in P[64] so it survives the shift into bit 63.
  assign w_p_add   = r_p[0] ? {w_cout, w_sum, r_p[31:0]} : r_p;
  assign w_p_shift = {1'b0, w_p_add[64:1]};

`ifdef SEQ_MUL_EARLY_TERM_EN
  logic [31:0] w_unconsumed;
  logic        w_early;
  logic [64:0] w_p_early;

  // Left-aligning P[31:0] by count discards the bits already consumed.
  assign w_unconsumed = r_p[31:0] << r_count;
  assign w_early      = (w_unconsumed == 32'h0);
  assign w_p_early    = r_p >> (6'd32 - r_count);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_count   <= 6'd0;
      r_p       <= 65'h0;
      r_mcand   <= 32'h0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= 64'h0;
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          r_done <= 1'b0;
          if (bus.i_start) begin
            r_mcand <= bus.i_a;
            r_p     <= {33'h0, bus.i_b};
            r_count <= 6'd0;
            r_busy  <= 1'b1;
            r_state <= StRun;
          end else begin
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end
        end
        StRun: begin
`ifdef SEQ_MUL_EARLY_TERM_EN
          if (w_early) begin
            r_p       <= w_p_early;
            r_product <= w_p_early[63:0];
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= StDone;
          end else
`endif
          begin
            r_p     <= w_p_shift;
            r_count <= r_count + 6'd1;
            if (r_count == 6'd31) begin
              r_product <= w_p_shift[63:0];
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
              r_state   <= StDone;
            end
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign bus.o_busy    = r_busy;
  assign bus.o_done    = r_done;
  assign bus.o_product = r_product;
endmodule

// File: tb/tb_seq_multiplier_32bit.sv
// Scoreboard bench for seq_multiplier_32bit: stimulus pushes expected results,
// a negedge monitor pops them when done pulses.
module tb_seq_multiplier_32bit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_multiplier_32bit_if bus ();

  seq_multiplier_32bit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [63:0] prod;
    int          acc;
    int          exp;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int latency(input logic [31:0] b);
`ifdef SEQ_MUL_EARLY_TERM_EN
    int msb;
    msb = -1;
    for (int i = 0; i < 32; i++) if (b[i]) msb = i;
    return (msb < 0) ? 1 : msb + 2;
`else
    return 32;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      check("busy_and_done", {63'h0, bus.o_busy & bus.o_done}, 64'h0);
      if (q.size() > 0 && cyc >= q[0].acc && cyc < q[0].exp)
        check("busy_in_run", {63'h0, bus.o_busy}, 64'h1);
      if (bus.o_done) begin
        if (q.size() == 0) begin
          check("spurious_done", 64'h1, 64'h0);
        end else begin
          e = q.pop_front();
          check("done_cycle", 64'(cyc), 64'(e.exp));
          check("product", bus.o_product, e.prod);
        end
      end else if (q.size() > 0 && cyc > q[0].exp) begin
        check("done_timeout", 64'(cyc), 64'(q[0].exp));
        void'(q.pop_front());
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    bus.i_start = 1'b1;
    bus.i_a     = a;
    bus.i_b     = b;
    e.prod = 64'(a) * 64'(b);
    e.acc  = cyc + 1;
    e.exp  = cyc + 1 + latency(b);
    q.push_back(e);
    @(negedge clk);
    bus.i_start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 200 && q.size() > 0; k++) @(negedge clk);
    if (q.size() > 0) begin
      check("idle_timeout", 64'(q.size()), 64'h0);
      q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e1;
    exp_t e2;
    logic [31:0] a;
    logic [31:0] b;
    bus.i_start = 1'b0;
    bus.i_a     = 32'h0;
    bus.i_b     = 32'h0;
    repeat (3) @(negedge clk);
    check("reset_busy", {63'h0, bus.o_busy}, 64'h0);
    check("reset_done", {63'h0, bus.o_done}, 64'h0);
    check("reset_product", bus.o_product, 64'h0);
    rst = 1'b0;

    // First start right after reset release must be accepted.
    issue(32'd3, 32'd5);
    wait_idle();
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle();
    issue(32'h1234_5678, 32'h0);
    wait_idle();

    // Start during RUN is ignored and must not disturb operands.
    issue(32'd7, 32'd9);
    repeat (8) @(negedge clk);
    bus.i_a = 32'd2;
    bus.i_b = 32'd2;
    bus.i_start = (q.size() > 0) && (cyc + 1 < q[0].exp);
    @(negedge clk);
    bus.i_start = 1'b0;
    wait_idle();

    // Asynchronous reset mid-operation.
    issue(32'd10, 32'd10);
    repeat (13) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_busy", {63'h0, bus.o_busy}, 64'h0);
    check("rst_done", {63'h0, bus.o_done}, 64'h0);
    check("rst_product", bus.o_product, 64'h0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    issue(32'd4, 32'd4);
    wait_idle();

    // start held high: second operation is accepted from DONE with no gap.
    bus.i_start = 1'b1;
    bus.i_a = 32'd6;
    bus.i_b = 32'd7;
    e1.prod = 64'd42;
    e1.acc  = cyc + 1;
    e1.exp  = cyc + 1 + latency(32'd7);
    q.push_back(e1);
    @(negedge clk);
    bus.i_a = 32'd8;
    bus.i_b = 32'd8;
    for (int k = 0; k < 100 && cyc < e1.exp; k++) @(negedge clk);
    e2.prod = 64'd64;
    e2.acc  = cyc + 1;
    e2.exp  = cyc + 1 + latency(32'd8);
    q.push_back(e2);
    @(negedge clk);
    bus.i_start = 1'b0;
    wait_idle();

    // Randomized operations with operand scrambling and ignored starts.
    for (int n = 0; n < 25; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      a = $urandom;
      b = ($urandom_range(0, 1) == 0) ? $urandom : ($urandom >> $urandom_range(0, 31));
      if (n == 0) b = 32'h0;
      issue(a, b);
      for (int k = 0; k < 100 && q.size() > 0; k++) begin
        @(negedge clk);
        bus.i_a = $urandom;
        bus.i_b = $urandom;
        bus.i_start = ($urandom_range(0, 3) == 0) && (q.size() > 0) && (cyc + 1 < q[0].exp);
      end
      bus.i_start = 1'b0;
      wait_idle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seq_multiplier_32bit.md
SEQ_MULTIPLIER_32BIT -- requirements
Module: seq_multiplier_32bit

Interface
REQ-001 The module SHALL have no parameters; all widths are fixed at 32-bit operands and a 64-bit product.
REQ-002 The module SHALL use one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request to begin a multiply; sampled on rising clk.
REQ-006 A  input  32  unsigned multiplicand, captured when start is accepted.
REQ-007 B  input  32  unsigned multiplier, captured when start is accepted.
REQ-008 busy  output  1  high while an operation is in progress (state RUN).
REQ-009 done  output  1  one-cycle pulse; product is valid while it is high.
REQ-010 product  output  64  unsigned A*B; holds its value until the next accepted start or reset.

Function
REQ-011 The block SHALL compute each partial sum with one full_adder_32bit instance, with Cin tied to 0; no other adder SHALL be inferred for the accumulation.
REQ-012 The FSM SHALL have three states, IDLE, RUN and DONE, with these transitions:
- IDLE to RUN on start.
- RUN to DONE after the final iteration.
- DONE to IDLE, or DONE to RUN on start.
REQ-013 Start acceptance:
- start SHALL be accepted only in IDLE or DONE.
- On acceptance, A is latched into mcand and P[64:0] loads {1'b0, 32'h0, B}.
- On acceptance, the iteration counter is cleared to 0.
REQ-014 In RUN, at each clk edge the block SHALL perform one iteration:
- If P[0]=1, {P[64], P[63:32]} is replaced by the adder's {Cout, SUM} of P[63:32]+mcand.
- The whole 65-bit P SHALL then shift right by 1, filling with 0.
- The counter increments by 1.
REQ-015 After the 32nd iteration the FSM SHALL enter DONE, and product SHALL equal P[63:0].
REQ-016 Latency: done SHALL assert exactly 32 cycles after the edge that accepted start, for exactly one cycle.
REQ-017 start asserted while busy SHALL be ignored and SHALL NOT disturb the operation in progress or its operands.
REQ-018 start asserted in DONE SHALL be accepted in that same cycle:
- done still pulses for that one cycle.
- The new operation begins with no idle gap.
REQ-019 busy SHALL be high in RUN only; done SHALL be high in DONE only; busy and done SHALL never both be high.
REQ-020 Changes on A and B after acceptance SHALL have no effect on the result.

Reset
REQ-021 Asserting rst SHALL asynchronously force all of the following, aborting any operation in progress:
- state to IDLE, counter to 0, P to 0, mcand to 0.
- busy to 0, done to 0, product to 64'h0.
REQ-022 After rst deasserts, the first start SHALL be accepted on the first rising clk at which it is sampled high.

Configuration
REQ-023 The block SHALL support one compile-time macro, SEQ_MUL_EARLY_TERM_EN.
REQ-024 Behaviour with SEQ_MUL_EARLY_TERM_EN defined:
- In any RUN cycle where the unconsumed multiplier bits, P[31-count:0], are all zero, P SHALL instead shift right by (32-count) in that single edge.
- The FSM SHALL then enter DONE.
- Latency becomes the number of iterations up to and including the most-significant set bit of B, plus 1; B=0 gives latency 1.
- The product SHALL be identical to the non-terminated result.
REQ-025 Behaviour without SEQ_MUL_EARLY_TERM_EN: latency SHALL be fixed at 32 cycles for all operands, and no early-termination logic SHALL be present.

Verification
REQ-026 A=3, B=5, start for one cycle -> done pulses 32 cycles later with product=64'h0000_0000_0000_000F; busy high for those 32 cycles.
REQ-027 A=32'hFFFF_FFFF, B=32'hFFFF_FFFF -> product=64'hFFFF_FFFE_0000_0001, which checks that the adder Cout is captured into P[64].
REQ-028 A=32'h1234_5678, B=0, start:
- With the macro: done after 1 cycle, product=0.
- Without the macro: done after 32 cycles, product=0.
REQ-029 Start A=7, B=9; at cycle 10 pulse start with A=2, B=2 -> the second start is ignored; product=63 at cycle 32.
REQ-030 Start A=10, B=10; assert rst at cycle 15 -> busy, done and product are 0 immediately; a new start with A=4, B=4 after release yields product=16.
REQ-031 Hold start high with operand pairs (6,7) then (8,8) -> done pulses at cycles 32 and 64 with product=42 then 64, and no idle cycle between the two operations.
